// File: rtl/fc_argmax.sv
// Argmax over the fc2 score vector: streams NUM_CLASSES signed words out of a
// read-only BRAM port at one per cycle and reports the index of the largest one.
module fc_argmax #(
    parameter int          NUM_CLASSES = 47,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [7:0]        result,
    output logic [DATA_W-1:0] max_score,
    output logic [31:0]       BRAM_ADDR,
    output logic              BRAM_EN,
    output logic [3:0]        BRAM_WE,
    output logic [31:0]       BRAM_DIN,
    input  logic [31:0]       BRAM_DOUT
);

    localparam logic [7:0] CNT_END  = 8'(NUM_CLASSES);
    localparam logic [7:0] LAST_IDX = 8'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t                    state;
    logic [7:0]                rd_idx;
    logic [7:0]                cmp_idx;
    logic [7:0]                run_idx;
    logic signed [DATA_W-1:0]  run_max;
    // [0]: read issued this cycle (drives EN), [1]: read data present on DOUT
    logic [1:0]                vld_pipe;

    logic signed [DATA_W-1:0]  score;
    logic                      take_new;
    logic signed [DATA_W-1:0]  nxt_max;
    logic [7:0]                nxt_idx;

    assign BRAM_EN  = vld_pipe[0];
    assign BRAM_WE  = 4'b0000;
    assign BRAM_DIN = 32'h0000_0000;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        score    = $signed(BRAM_DOUT[DATA_W-1:0]);
        take_new = (cmp_idx == 8'd0) || (score > run_max);
        nxt_max  = take_new ? score : run_max;
        nxt_idx  = take_new ? cmp_idx : run_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= 8'd0;
            max_score <= '0;
            vld_pipe  <= 2'b00;
            BRAM_ADDR <= BASE_ADDR;
            rd_idx    <= 8'd0;
            cmp_idx   <= 8'd0;
            run_idx   <= 8'd0;
            run_max   <= '0;
        end else begin
            done        <= 1'b0;
            vld_pipe[1] <= vld_pipe[0];

            if (vld_pipe[1]) begin
                run_max <= nxt_max;
                run_idx <= nxt_idx;
                cmp_idx <= cmp_idx + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        // Score 0 is issued on the accepting edge, so the issue
                        // counter starts one ahead.
                        state       <= SCAN;
                        busy        <= 1'b1;
                        vld_pipe[0] <= 1'b1;
                        BRAM_ADDR   <= BASE_ADDR;
                        rd_idx      <= 8'd1;
                        cmp_idx     <= 8'd0;
                    end
                end
                SCAN: begin
                    if (rd_idx == CNT_END) begin
                        vld_pipe[0] <= 1'b0;
                        state       <= DRAIN;
                    end else begin
                        BRAM_ADDR <= BASE_ADDR + {22'd0, rd_idx, 2'b00};
                        rd_idx    <= rd_idx + 8'd1;
                    end
                end
                DRAIN: begin
                    if (vld_pipe[1] && (cmp_idx == LAST_IDX)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= nxt_idx;
                        max_score <= nxt_max;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_argmax.sv
// Directed bench for fc_argmax: BRAM model with one-cycle read latency, per-cycle
// checks of EN/ADDR/busy/done timing relative to the accepting edge E0.
module tb_fc_argmax;

    localparam int NC = 47;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [7:0]  result;
    logic [31:0] max_score;
    logic [31:0] bram_addr;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;

    logic [31:0] mem [0:255];

    int vectors;
    int miscompares;
    int en_cnt, done_cnt, done_e, addr_err, busy_err;

    fc_argmax #(.NUM_CLASSES(NC), .BASE_ADDR(32'h0), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .max_score (max_score),
        .BRAM_ADDR (bram_addr),
        .BRAM_EN   (bram_en),
        .BRAM_WE   (bram_we),
        .BRAM_DIN  (bram_din),
        .BRAM_DOUT (bram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_en) bram_dout <= mem[bram_addr[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Pulses start in an IDLE cycle (sampled at E0) and then watches each cycle
    // after E(k). Extra start pulses / a reset can be injected at given edges.
    task automatic run(input int re1, input int re2, input int rst_e);
        en_cnt = 0; done_cnt = 0; done_e = -1; addr_err = 0; busy_err = 0;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        start = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 70; e++) begin
            @(negedge clk);
            start = (e == re1) || (e == re2);
            rst   = (rst_e > 0) && (e == rst_e);
            if (bram_en) begin
                if (bram_addr !== 32'(en_cnt * 4)) addr_err++;
                en_cnt++;
            end
            if (busy !== (((e - 1) <= NC) && !(rst_e > 0 && (e - 1) >= rst_e))) busy_err++;
            if (rst_e > 0 && (e - 1) == rst_e) begin
                chk("rst_en",     {31'd0, bram_en}, 32'd0);
                chk("rst_busy",   {31'd0, busy}, 32'd0);
                chk("rst_result", {24'd0, result}, 32'd0);
                chk("rst_max",    max_score, 32'd0);
            end
            if (done) begin
                done_cnt++;
                done_e = e - 1;
                break;
            end
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic chk_run(input string tag, input logic [7:0] exp_idx, input logic [31:0] exp_max);
        chk({tag, "_done_cnt"}, done_cnt, 32'd1);
        chk({tag, "_done_edge"}, done_e, NC + 1);
        chk({tag, "_en_cnt"}, en_cnt, NC);
        chk({tag, "_addr_err"}, addr_err, 32'd0);
        chk({tag, "_busy_err"}, busy_err, 32'd0);
        chk({tag, "_result"}, {24'd0, result}, {24'd0, exp_idx});
        chk({tag, "_max"}, max_score, exp_max);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy",   {31'd0, busy}, 32'd0);
        chk("reset_done",   {31'd0, done}, 32'd0);
        chk("reset_result", {24'd0, result}, 32'd0);
        chk("reset_max",    max_score, 32'd0);
        chk("reset_en",     {31'd0, bram_en}, 32'd0);
        chk("reset_addr",   bram_addr, 32'd0);
        chk("reset_we",     {28'd0, bram_we}, 32'd0);
        chk("reset_din",    bram_din, 32'd0);
        rst = 1'b0;

        // Ramp 0..46
        for (int i = 0; i < NC; i++) mem[i] = 32'(i);
        run(0, 0, 0);
        chk_run("ramp", 8'd46, 32'd46);

        // Negative field with a single -5 at index 39
        for (int i = 0; i < NC; i++) mem[i] = -32'sd1000;
        mem[39] = -32'sd5;
        run(0, 0, 0);
        chk_run("neg", 8'd39, 32'hFFFF_FFFB);

        // Ties keep the lower index; 0x80000000 is the most negative value
        for (int i = 0; i < NC; i++) mem[i] = 32'd0;
        mem[0]  = 32'h8000_0000;
        mem[5]  = 32'd7;
        mem[20] = 32'd7;
        run(0, 0, 0);
        chk_run("tie", 8'd5, 32'd7);

        // All equal
        for (int i = 0; i < NC; i++) mem[i] = 32'h1234_5678;
        run(0, 0, 0);
        chk_run("equal", 8'd0, 32'h1234_5678);

        // Start re-pulsed mid-run is ignored
        for (int i = 0; i < NC; i++) mem[i] = 32'(i);
        run(10, 30, 0);
        chk_run("restart", 8'd46, 32'd46);

        // Back-to-back: start in the IDLE cycle right after done, reversed ramp
        for (int i = 0; i < NC; i++) mem[i] = 32'(NC - 1 - i);
        run(0, 0, 0);
        chk_run("b2b", 8'd0, 32'd46);

        // Reset at E20 aborts the run with no done
        for (int i = 0; i < NC; i++) mem[i] = 32'(i);
        run(0, 0, 20);
        chk("abort_done_cnt", done_cnt, 32'd0);
        chk("abort_en_cnt", en_cnt, 32'd20);
        chk("abort_addr_err", addr_err, 32'd0);
        chk("abort_busy_err", busy_err, 32'd0);

        // Fresh run after the abort
        run(0, 0, 0);
        chk_run("post_abort", 8'd46, 32'd46);

        chk("const_we",  {28'd0, bram_we}, 32'd0);
        chk("const_din", bram_din, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fc_argmax.md
# fc_argmax

Output classifier stage placed directly downstream of the fc2 layer in the cnn accelerator. When started, it reads the NUM_CLASSES signed 32-bit fc2 scores from a word BRAM and finds the largest one. It then reports that score's index as the 8-bit inference result with a one-cycle done pulse. It drives a standard BRAM port (ADDR/WE/EN/DIN/DOUT) identical to those used by the cnn core's IF/W memories and never writes.

## Interface
- NUM_CLASSES, 47, number of fc2 scores to scan (1..255)
- BASE_ADDR, 0, byte address of score 0
- DATA_W, 32, score width, two's-complement signed

- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  one-cycle request; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when result is valid
- result  output  8  index of maximum score; holds until the next completion
- max_score  output  DATA_W  value of the winning score; holds with result
- BRAM_ADDR  output  32  byte address, step 4 per score
- BRAM_EN  output  1  read enable
- BRAM_WE  output  4  constant 4'b0000
- BRAM_DIN  output  32  constant 0
- BRAM_DOUT  input  32  read data, valid on the edge after the edge that samples EN/ADDR

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: on start=1, go to SCAN, set busy=1, and clear the issue counter rd_idx and the compare counter cmp_idx.
- SCAN: each cycle, drive EN=1 and ADDR=BASE_ADDR+4*rd_idx, then increment rd_idx. After issuing index NUM_CLASSES-1, go to DRAIN with EN=0.
- A valid flag pipeline of 2 stages tracks the issued reads. When a read reaches the compare stage, BRAM_DOUT is evaluated for that cmp_idx.
- Compare rule:
  - cmp_idx==0 unconditionally loads the running max and index 0.
  - For any other cmp_idx, the entry is replaced only if DOUT > running max as a signed compare.
  - Ties therefore keep the lowest index.
- DRAIN: wait until compare of index NUM_CLASSES-1, then go to DONE.
- DONE: one cycle with done=1 and busy=0. result and max_score are updated on the same edge that enters DONE. The next state is IDLE.
- start while busy or in DONE: ignored, not queued.
- result width: the index is zero-extended to 8 bits.

## Timing
- Edge E0 samples start=1 in IDLE.
- EN=1 with address k is present during the cycle following edge E(k).
- BRAM samples address k at edge E(k+1); data k is compared at edge E(k+2).
- The last compare is at E(NUM_CLASSES+1). done is high during the cycle after E(NUM_CLASSES+1). For the default 47 classes, the done cycle follows E48.
- Throughput is one score per cycle; there are no bubbles in SCAN.
- Reset values: busy=0, done=0, result=0, max_score=0, BRAM_EN=0, BRAM_ADDR=BASE_ADDR, state IDLE.
- rst mid-scan: on the next edge, all outputs return to reset values. Partial results are discarded and no done is produced.
- rst and start on the same edge: rst wins and start is lost.
- start on the cycle after done (IDLE again) is accepted; back-to-back runs are separated by exactly one IDLE cycle.

## Test plan
- Ramp: BRAM holds scores 0..46, start pulsed -> busy through the run, a single done in the cycle after E48, result=46, max_score=46, and EN seen for exactly 47 cycles with addresses 0,4,...,184.
- Negative field: all scores are -1000 except index 39, which holds -5 -> result=39 (the expected inference result for the reference input image), max_score=32'hFFFFFFFB.
- Tie and sign: scores 7 at indices 5 and 20, 32'h80000000 at index 0, and 0 elsewhere -> result=5. This checks that a large unsigned-looking value loses under signed compare.
- All equal: all scores 0x12345678 -> result=0.
- start re-pulsed at E10 and E30 during a run -> ignored, exactly one done, result unchanged from the single-run value. Then a new start in the IDLE cycle after done, with memory reloaded as a ramp reversed -> second done, result=0.
- rst asserted at E20 mid-scan -> from the next cycle EN=0, busy=0, result=0, and no done appears. A subsequent start gives the correct full result.
